// File: rtl/echo_pkg.sv
// Shared definitions for the feedback echo: gain format, FSM encoding, saturation.
package echo_pkg;

  localparam int unsigned FRAC_DEF = 14;
  localparam logic [15:0] Q_ONE    = 16'h4000;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_CALC  = 3'd4,
    S_WR    = 3'd5
  } state_t;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous delay-line RAM, one-cycle read latency, contents not reset.
module delay_ram #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/echo_fb.sv
// Multi-channel feedback echo: per-channel delay line, feedback gain, wet/dry mix.
module echo_fb
  import echo_pkg::*;
#(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned FRAC     = FRAC_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic                         enable,
  input  logic [CHANNELS*BITSIZE-1:0]  in,
  input  logic [ADDR_W-1:0]            delay,
  input  logic [BITSIZE-1:0]           fb_gain,
  input  logic [BITSIZE-1:0]           wet_gain,
  input  logic [BITSIZE-1:0]           dry_gain,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned RAM_AW = ADDR_W + CH_W;
  localparam int unsigned PROD_W = 2 * BITSIZE;
  localparam int unsigned SUM_W  = 2 * BITSIZE + 2;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [RAM_AW-1:0]             r_clr;
  logic [ADDR_W-1:0]             r_wp;
  logic [ADDR_W-1:0]             r_delay;
  logic [CH_W-1:0]               r_ch;
  logic [CHANNELS*BITSIZE-1:0]   r_in;
  logic [CHANNELS*BITSIZE-1:0]   r_ybuf;
  logic [CHANNELS*BITSIZE-1:0]   r_out;
  logic signed [BITSIZE-1:0]     r_fb;
  logic signed [BITSIZE-1:0]     r_wet;
  logic signed [BITSIZE-1:0]     r_dry;
  logic signed [BITSIZE-1:0]     r_wr;
  logic                          r_en;
  logic                          r_out_valid;
  logic                          r_busy;
  logic                          r_overrun;

  logic                          w_last;
  logic [ADDR_W-1:0]             w_d;
  logic [ADDR_W-1:0]             w_rd_ptr;
  logic signed [BITSIZE-1:0]     w_in_ch;
  logic signed [BITSIZE-1:0]     w_rd;
  logic signed [PROD_W-1:0]      w_prod_fb;
  logic signed [PROD_W-1:0]      w_prod_wet;
  logic signed [PROD_W-1:0]      w_prod_dry;
  logic signed [PROD_W-1:0]      w_fb_term;
  logic signed [SUM_W-1:0]       w_wr_sum;
  logic signed [SUM_W-1:0]       w_mix;
  logic signed [BITSIZE-1:0]     w_wr_val;
  logic signed [BITSIZE-1:0]     w_y_val;
  logic                          w_ram_we;
  logic                          w_ram_re;
  logic [RAM_AW-1:0]             w_ram_addr;
  logic [BITSIZE-1:0]            w_ram_wdata;

  // Delay of zero frames is meaningless for a feedback loop; treat it as one.
  assign w_d      = (r_delay == '0) ? ADDR_W'(1) : r_delay;
  assign w_rd_ptr = r_wp - w_d;
  assign w_last   = (r_ch == CH_W'(CHANNELS - 1));
  assign w_in_ch  = r_in[32'(r_ch) * BITSIZE +: BITSIZE];

  // Shared MAC: full-precision products, arithmetic shift, saturate.
  assign w_prod_fb  = PROD_W'(w_rd) * PROD_W'(r_fb);
  assign w_prod_wet = PROD_W'(w_rd) * PROD_W'(r_wet);
  assign w_prod_dry = PROD_W'(w_in_ch) * PROD_W'(r_dry);
  assign w_fb_term  = w_prod_fb >>> FRAC;
  assign w_wr_sum   = SUM_W'(w_in_ch) + SUM_W'(w_fb_term);
  assign w_mix      = (SUM_W'(w_prod_dry) + SUM_W'(w_prod_wet)) >>> FRAC;
  assign w_wr_val   = r_en ? BITSIZE'(sat(64'(w_wr_sum), BITSIZE)) : w_in_ch;
  assign w_y_val    = r_en ? BITSIZE'(sat(64'(w_mix), BITSIZE))    : w_in_ch;

  delay_ram #(
    .W  (BITSIZE),
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rd)
  );

  // FSM state register; reset restarts the RAM clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and RAM port control.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    unique case (r_state)
      S_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr;
        if (r_clr == '1) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (sample_valid) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_ram_re    = 1'b1;
        w_ram_addr  = {w_rd_ptr, r_ch};
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = {r_wp, r_ch};
        w_ram_wdata = r_wr;
        w_state_nxt = w_last ? S_IDLE : S_RD;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Datapath, frame latches and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr       <= '0;
      r_wp        <= '0;
      r_delay     <= '0;
      r_ch        <= '0;
      r_in        <= '0;
      r_ybuf      <= '0;
      r_out       <= '0;
      r_fb        <= '0;
      r_wet       <= '0;
      r_dry       <= '0;
      r_wr        <= '0;
      r_en        <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (sample_valid && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        S_CLEAR: begin
          r_clr <= r_clr + RAM_AW'(1);
        end
        S_IDLE: begin
          if (sample_valid) begin
            r_in    <= in;
            r_delay <= delay;
            r_fb    <= fb_gain;
            r_wet   <= wet_gain;
            r_dry   <= dry_gain;
            r_en    <= enable;
            r_ch    <= '0;
          end
        end
        S_CALC: begin
          r_wr <= w_wr_val;
          r_ybuf[32'(r_ch) * BITSIZE +: BITSIZE] <= w_y_val;
        end
        S_WR: begin
          if (w_last) begin
            r_wp        <= r_wp + ADDR_W'(1);
            r_out       <= r_ybuf;
            r_out_valid <= 1'b1;
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule
